// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling
module uart_rx_8n1 #(
    parameter int input_clk_hz = 1_000_000,
    parameter int baud_rate    = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_ready,
    output logic [7:0] o_data
);
    localparam int CLKS_PER_BIT = input_clk_hz / baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          ready_d;
    logic          rx_m, rx_s;

    // Synchronize the serial line; preset high so an undriven line reads as idle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            o_data  <= '0;
            o_ready <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            o_data  <= data_d;
            o_ready <= ready_d;
        end
    end

    // Frame sequencing: start check at half bit, data and stop sampled at bit centres.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = o_data;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == LAST_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed frames against uart_rx_8n1 at 1 MHz / 9600 baud
`timescale 1ns/1ps
module tb_uart_rx_8n1;
    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready;
    logic [7:0] data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int run = 0;
    int max_run = 0;
    int start_cyc = 0;
    int ready_cyc = 0;
    int p0;
    logic [7:0] got_q[$];

    uart_rx_8n1 #(.input_clk_hz(1_000_000), .baud_rate(9600)) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_rx(rx),
        .o_ready(ready),
        .o_data(data)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ready) begin
            pulses++;
            ready_cyc = cyc;
            got_q.push_back(data);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BIT);
        end
        rx = stop;
        idle(BIT);
    endtask

    initial begin
        idle(5);
        check("rst_ready", ready, 0);
        check("rst_data", data, 8'h00);
        rst_n = 1'b1;
        idle(2 * BIT);
        check("idle_pulses", pulses, 0);

        p0 = pulses;
        send_byte(8'h66, 1'b1);
        check("b66_pulses", pulses - p0, 1);
        check("b66_data", got_q[$], 8'h66);
        check("b66_latency_ok", (ready_cyc - start_cyc >= 988) && (ready_cyc - start_cyc <= 994), 1);
        idle(BIT);
        check("b66_held", data, 8'h66);

        p0 = pulses;
        got_q.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(BIT);
        check("b2b_pulses", pulses - p0, 2);
        check("b2b_first", got_q[0], 8'h00);
        check("b2b_second", got_q[1], 8'hFF);
        check("b2b_held", data, 8'hFF);

        p0 = pulses;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(2 * BIT);
        check("glitch_pulses", pulses - p0, 0);
        send_byte(8'hA5, 1'b1);
        idle(BIT);
        check("a5_pulses", pulses - p0, 1);
        check("a5_data", data, 8'hA5);

        p0 = pulses;
        send_byte(8'h3C, 1'b0);
        idle(3 * BIT);
        rx = 1'b1;
        idle(2 * BIT);
        check("frm_pulses", pulses - p0, 0);
        check("frm_data", data, 8'hA5);
        send_byte(8'h81, 1'b1);
        idle(BIT);
        check("b81_pulses", pulses - p0, 1);
        check("b81_data", data, 8'h81);

        p0 = pulses;
        rx = 1'b0;
        idle(BIT);
        rx = 1'b1;
        idle(BIT);
        rx = 1'b0;
        idle(BIT / 2);
        rst_n = 1'b0;
        idle(3);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_data", data, 8'h00);
        rx = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(12 * BIT);
        check("mid_rst_pulses", pulses - p0, 0);
        check("mid_rst_data_after", data, 8'h00);
        send_byte(8'h5A, 1'b1);
        idle(BIT);
        check("b5a_pulses", pulses - p0, 1);
        check("b5a_data", data, 8'h5A);

        check("pulse_width", max_run, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
